// File: rtl/xor_bank_seq.sv
// WIDTH-channel clocked XOR bank. Each beat computes either A^B or ACC^B,
// where ACC holds the previous result. The result then runs through a STAGES-deep valid pipeline.
module xor_bank_seq #(
    parameter int               WIDTH  = 4,
    parameter int               STAGES = 1,
    parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             vld_o,
    output logic             p_o
);

    function automatic logic parity_even(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  result_d;
    logic              accept_d;
    logic [WIDTH-1:0]  stg_data_q [STAGES];
    logic [WIDTH-1:0]  stg_data_d [STAGES];
    logic [STAGES-1:0] stg_vld_q;
    logic [STAGES-1:0] stg_vld_d;

    // Stage-0 operand select. In toggle mode A is never looked at, so an X on A cannot leak.
    always_comb begin
        accept_d = en_i & ~sclr_i;
        if (mode_i) begin
            result_d = acc_q ^ b_i;
        end else begin
            result_d = a_i ^ b_i;
        end
    end

    // Accumulator next state: clear has priority, and the accumulator loads only on accepted beats.
    always_comb begin
        acc_d = acc_q;
        if (sclr_i) begin
            acc_d = INIT;
        end else if (accept_d) begin
            acc_d = result_d;
        end else begin
            acc_d = acc_q;
        end
    end

    // Pipeline next state. A stage captures data only when its incoming valid is set.
    // This also gives the hold-last-value behaviour of the final stage (Y).
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stg_data_d[i] = stg_data_q[i];
        end
        stg_vld_d = {STAGES{1'b0}};
        if (sclr_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stg_data_d[i] = INIT;
            end
            stg_vld_d = {STAGES{1'b0}};
        end else begin
            stg_vld_d[0] = accept_d;
            if (accept_d) begin
                stg_data_d[0] = result_d;
            end else begin
                stg_data_d[0] = stg_data_q[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                stg_vld_d[i] = stg_vld_q[i-1];
                if (stg_vld_q[i-1]) begin
                    stg_data_d[i] = stg_data_q[i-1];
                end else begin
                    stg_data_d[i] = stg_data_q[i];
                end
            end
        end
    end

    // State registers. An async reset drops all in-flight beats immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= INIT;
            stg_vld_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                stg_data_q[i] <= INIT;
            end
        end else begin
            acc_q     <= acc_d;
            stg_vld_q <= stg_vld_d;
            for (int i = 0; i < STAGES; i++) begin
                stg_data_q[i] <= stg_data_d[i];
            end
        end
    end

    assign y_o   = stg_data_q[STAGES-1];
    assign vld_o = stg_vld_q[STAGES-1];
    assign p_o   = parity_even(stg_data_q[STAGES-1]);

endmodule
